// File: rtl/gpio_ctrl_pkg.sv
// gpio_ctrl_pkg: shared constants for the GPIO controller.
//   - GPIO_BUS_DW: core data-bus width.
//   - GPIO_REG_*: register word indices (bus_addr[4:2]).
//   - GPIO_DEB_CNT_W: width of the per-pin debounce counters (DEB_CNT <= 15).
package gpio_ctrl_pkg;

  localparam int GPIO_BUS_DW    = 32;
  localparam int GPIO_DEB_CNT_W = 4;

  localparam logic [2:0] GPIO_REG_DATA_IN  = 3'd0;
  localparam logic [2:0] GPIO_REG_DATA_OUT = 3'd1;
  localparam logic [2:0] GPIO_REG_DIR      = 3'd2;
  localparam logic [2:0] GPIO_REG_IRQ_EN   = 3'd3;
  localparam logic [2:0] GPIO_REG_IRQ_EDGE = 3'd4;
  localparam logic [2:0] GPIO_REG_IRQ_PEND = 3'd5;
  localparam logic [2:0] GPIO_REG_OUT_SET  = 3'd6;
  localparam logic [2:0] GPIO_REG_OUT_CLR  = 3'd7;

endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: per-pin debounce counters and the stable input register.
// A pin's stable level only follows din after DEB_CNT consecutive ticks in
// which din differed from it; any agreement in between restarts the count.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : one-cycle sample strobe from the shared prescaler
//   din        : synchronized pin levels
//   dout       : debounced (stable) pin levels, registered
module gpio_debounce
  import gpio_ctrl_pkg::*;
#(
  parameter int GPIO_W  = 8,
  parameter int DEB_CNT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [GPIO_W-1:0] din,
  output logic [GPIO_W-1:0] dout
);

  localparam logic [GPIO_DEB_CNT_W-1:0] CNT_LAST = GPIO_DEB_CNT_W'(DEB_CNT - 1);

  logic [GPIO_W-1:0][GPIO_DEB_CNT_W-1:0] cnt_q, cnt_d;
  logic [GPIO_W-1:0]                     stable_q, stable_d;

  // Next-state for each pin's mismatch counter and stable level.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    for (int i = 0; i < GPIO_W; i++) begin
      if (din[i] == stable_q[i]) begin
        cnt_d[i] = {GPIO_DEB_CNT_W{1'b0}};
      end else if (tick) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = din[i];
          cnt_d[i]    = {GPIO_DEB_CNT_W{1'b0}};
        end else begin
          cnt_d[i] = cnt_q[i] + GPIO_DEB_CNT_W'(1);
        end
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Counter and stable-level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= {(GPIO_W*GPIO_DEB_CNT_W){1'b0}};
      stable_q <= {GPIO_W{1'b0}};
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign dout = stable_q;

endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO controller.
// Synchronizes the pin inputs (two flops), optionally debounces them, detects
// selectable rising/falling edges into a W1C pending register and drives a
// registered level interrupt. Outputs and output enables come from registers.
// Optional feature macro: GPIO_DEBOUNCE_EN (debouncer + prescaler present);
// without it the synchronizer output is simply registered into DATA_IN.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus_req/we/addr/wdata : single-cycle access, word index in bus_addr[4:2]
//   bus_rdata/bus_ack   : response one cycle after bus_req
//   gpio_pin_in         : asynchronous pin inputs
//   gpio_pin_out/oe     : output levels and drive enables
//   irq                 : level interrupt, active-high
module gpio_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int GPIO_W  = 8,
  parameter int DEB_DIV = 1000,
  parameter int DEB_CNT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   bus_req,
  input  logic                   bus_we,
  input  logic [4:0]             bus_addr,
  input  logic [GPIO_BUS_DW-1:0] bus_wdata,
  output logic [GPIO_BUS_DW-1:0] bus_rdata,
  output logic                   bus_ack,
  input  logic [GPIO_W-1:0]      gpio_pin_in,
  output logic [GPIO_W-1:0]      gpio_pin_out,
  output logic [GPIO_W-1:0]      gpio_pin_oe,
  output logic                   irq
);

  logic [GPIO_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [GPIO_W-1:0] stable_s, stable_dly_q, stable_dly_d;
  logic [GPIO_W-1:0] data_out_q, data_out_d, dir_q, dir_d;
  logic [GPIO_W-1:0] irq_en_q, irq_en_d, irq_edge_q, irq_edge_d;
  logic [GPIO_W-1:0] pend_q, pend_d;
  logic [GPIO_W-1:0] ev_s, w1c_s, wdata_s;
  logic [GPIO_BUS_DW-1:0] rdata_q, rdata_d;
  logic              ack_q, ack_d, irq_q, irq_d;
  logic              unused_s;

  // Register bits above GPIO_W read back as zero.
  function automatic logic [GPIO_BUS_DW-1:0] zext(input logic [GPIO_W-1:0] v);
    logic [GPIO_BUS_DW-1:0] r;
    r           = {GPIO_BUS_DW{1'b0}};
    r[GPIO_W-1:0] = v;
    return r;
  endfunction

  assign wdata_s  = bus_wdata[GPIO_W-1:0];
  // Address byte-offset bits, upper write-data bits and the debounce
  // parameters are intentionally not needed in every build.
  assign unused_s = ^{bus_addr[1:0], bus_wdata} ^ (DEB_DIV > 1) ^ (DEB_CNT > 0);

`ifdef GPIO_DEBOUNCE_EN
  localparam int PRE_W = $clog2(DEB_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DEB_DIV - 1);

  logic [PRE_W-1:0] presc_q, presc_d;
  logic             tick_s;

  // Free-running prescaler; tick marks its last count.
  always_comb begin
    tick_s = (presc_q == PRE_LAST);
    if (tick_s) begin
      presc_d = {PRE_W{1'b0}};
    end else begin
      presc_d = presc_q + PRE_W'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= {PRE_W{1'b0}};
    end else begin
      presc_q <= presc_d;
    end
  end

  gpio_debounce #(
    .GPIO_W (GPIO_W),
    .DEB_CNT(DEB_CNT)
  ) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick_s),
    .din  (sync2_q),
    .dout (stable_s)
  );
`else
  logic [GPIO_W-1:0] stable_q;

  // Without debouncing the stable level is the synchronizer output, one flop later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= {GPIO_W{1'b0}};
    end else begin
      stable_q <= sync2_q;
    end
  end

  assign stable_s = stable_q;
`endif

  // Bus decode, edge detection and next-state for all controller registers.
  always_comb begin
    sync1_d      = gpio_pin_in;
    sync2_d      = sync1_q;
    stable_dly_d = stable_s;
    data_out_d   = data_out_q;
    dir_d        = dir_q;
    irq_en_d     = irq_en_q;
    irq_edge_d   = irq_edge_q;
    w1c_s        = {GPIO_W{1'b0}};
    rdata_d      = {GPIO_BUS_DW{1'b0}};
    ack_d        = bus_req;
    ev_s = (irq_edge_q & stable_s & ~stable_dly_q) |
           (~irq_edge_q & ~stable_s & stable_dly_q);
    if (bus_req) begin
      if (bus_we) begin
        case (bus_addr[4:2])
          GPIO_REG_DATA_OUT: data_out_d = wdata_s;
          GPIO_REG_DIR:      dir_d      = wdata_s;
          GPIO_REG_IRQ_EN:   irq_en_d   = wdata_s;
          GPIO_REG_IRQ_EDGE: irq_edge_d = wdata_s;
          GPIO_REG_IRQ_PEND: w1c_s      = wdata_s;
          GPIO_REG_OUT_SET:  data_out_d = data_out_q | wdata_s;
          GPIO_REG_OUT_CLR:  data_out_d = data_out_q & ~wdata_s;
          default:           data_out_d = data_out_q; // DATA_IN is read-only
        endcase
      end else begin
        case (bus_addr[4:2])
          GPIO_REG_DATA_IN:  rdata_d = zext(stable_s);
          GPIO_REG_DATA_OUT: rdata_d = zext(data_out_q);
          GPIO_REG_DIR:      rdata_d = zext(dir_q);
          GPIO_REG_IRQ_EN:   rdata_d = zext(irq_en_q);
          GPIO_REG_IRQ_EDGE: rdata_d = zext(irq_edge_q);
          GPIO_REG_IRQ_PEND: rdata_d = zext(pend_q);
          default:           rdata_d = {GPIO_BUS_DW{1'b0}}; // OUT_SET/OUT_CLR are write-only
        endcase
      end
    end else begin
      rdata_d = {GPIO_BUS_DW{1'b0}};
    end
    // A new event overrides a same-cycle W1C so no edge is ever lost.
    pend_d = (pend_q & ~w1c_s) | ev_s;
    irq_d  = |(pend_q & irq_en_q);
  end

  // Controller register bank, synchronizer and bus response flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= {GPIO_W{1'b0}};
      sync2_q      <= {GPIO_W{1'b0}};
      stable_dly_q <= {GPIO_W{1'b0}};
      data_out_q   <= {GPIO_W{1'b0}};
      dir_q        <= {GPIO_W{1'b0}};
      irq_en_q     <= {GPIO_W{1'b0}};
      irq_edge_q   <= {GPIO_W{1'b1}};
      pend_q       <= {GPIO_W{1'b0}};
      rdata_q      <= {GPIO_BUS_DW{1'b0}};
      ack_q        <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_dly_q <= stable_dly_d;
      data_out_q   <= data_out_d;
      dir_q        <= dir_d;
      irq_en_q     <= irq_en_d;
      irq_edge_q   <= irq_edge_d;
      pend_q       <= pend_d;
      rdata_q      <= rdata_d;
      ack_q        <= ack_d;
      irq_q        <= irq_d;
    end
  end

  assign bus_rdata    = rdata_q;
  assign bus_ack      = ack_q;
  assign gpio_pin_out = data_out_q;
  assign gpio_pin_oe  = dir_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: self-checking bench for gpio_ctrl.
// Register accesses go through a scoreboard queue: the expected read data is
// pushed when the request is driven and popped when bus_ack is seen.
// A table of register vectors covers the map; hand-written sequences cover
// input latency, interrupts, edge polarity, W1C races and mid-access reset.
module tb_gpio_ctrl;
  import gpio_ctrl_pkg::*;

  localparam int W = 8;
`ifdef GPIO_DEBOUNCE_EN
  localparam int SETTLE = 40;
`else
  localparam int SETTLE = 8;
`endif

  logic          clk;
  logic          rst_n;
  logic          bus_req;
  logic          bus_we;
  logic [4:0]    bus_addr;
  logic [31:0]   bus_wdata;
  logic [31:0]   bus_rdata;
  logic          bus_ack;
  logic [W-1:0]  pin_in;
  logic [W-1:0]  pin_out;
  logic [W-1:0]  pin_oe;
  logic          irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        chk;
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic        we;
    logic [2:0]  idx;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
    logic [7:0]  exp_oe;
    string       name;
  } vec_t;

  gpio_ctrl #(.GPIO_W(W), .DEB_DIV(4), .DEB_CNT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .bus_ack     (bus_ack),
    .gpio_pin_in (pin_in),
    .gpio_pin_out(pin_out),
    .gpio_pin_oe (pin_oe),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every ack pops one expectation; idle rdata must be 0.
  always @(negedge clk) begin
    sb_t e;
    if (rst_n && bus_ack) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_ack: got ack with empty scoreboard, rdata 0x%08h", bus_rdata);
      end else begin
        e = sb.pop_front();
        if (e.chk) check(e.name, bus_rdata, e.exp);
      end
    end else if (rst_n) begin
      check("rdata_idle", bus_rdata, 32'h0);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_cycle(input logic we, input logic [2:0] idx, input logic [31:0] wd,
                           input logic chk, input logic [31:0] exp, input string name);
    sb_t e;
    bus_req   = 1'b1;
    bus_we    = we;
    bus_addr  = {idx, 2'b11};
    bus_wdata = wd;
    e.chk = chk;
    e.exp = exp;
    e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_wdata = 32'h0;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] wd);
    bus_cycle(1'b1, idx, wd, 1'b0, 32'h0, "wr");
  endtask

  task automatic rd(input logic [2:0] idx, input logic [31:0] exp, input string name);
    bus_cycle(1'b0, idx, 32'h0, 1'b1, exp, name);
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] idx, input logic [31:0] wd,
                              input logic [31:0] exp_rd, input logic [7:0] exp_out,
                              input logic [7:0] exp_oe, input string name);
    vec_t v;
    v.we = we; v.idx = idx; v.wd = wd; v.exp_rd = exp_rd;
    v.exp_out = exp_out; v.exp_oe = exp_oe; v.name = name;
    return v;
  endfunction

  // Watchdog: the sequence is linear, so this only fires on a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[18];
    bus_req = 1'b0; bus_we = 1'b0; bus_addr = 5'd0; bus_wdata = 32'h0;
    pin_in = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(bus_ack), 32'h0);
    check("rst_rdata", bus_rdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_out", 32'(pin_out), 32'h0);
    check("rst_oe", 32'(pin_oe), 32'h0);
    rst_n = 1'b1;
    cycles(1);

    tbl[0]  = mk(1'b0, GPIO_REG_DIR,      32'h0,        32'h0,  8'h00, 8'h00, "rd_dir_rst");
    tbl[1]  = mk(1'b0, GPIO_REG_IRQ_EDGE, 32'h0,        32'hFF, 8'h00, 8'h00, "rd_edge_rst");
    tbl[2]  = mk(1'b0, GPIO_REG_IRQ_PEND, 32'h0,        32'h0,  8'h00, 8'h00, "rd_pend_rst");
    tbl[3]  = mk(1'b1, GPIO_REG_DATA_OUT, 32'hA5,       32'h0,  8'hA5, 8'h00, "wr_out_a5");
    tbl[4]  = mk(1'b1, GPIO_REG_OUT_SET,  32'h0F,       32'h0,  8'hAF, 8'h00, "wr_set_0f");
    tbl[5]  = mk(1'b1, GPIO_REG_OUT_CLR,  32'h81,       32'h0,  8'h2E, 8'h00, "wr_clr_81");
    tbl[6]  = mk(1'b0, GPIO_REG_OUT_SET,  32'h0,        32'h0,  8'h2E, 8'h00, "rd_set_wo");
    tbl[7]  = mk(1'b0, GPIO_REG_OUT_CLR,  32'h0,        32'h0,  8'h2E, 8'h00, "rd_clr_wo");
    tbl[8]  = mk(1'b0, GPIO_REG_DATA_OUT, 32'h0,        32'h2E, 8'h2E, 8'h00, "rd_out");
    tbl[9]  = mk(1'b1, GPIO_REG_DIR,      32'hFFFFFF3C, 32'h0,  8'h2E, 8'h3C, "wr_dir");
    tbl[10] = mk(1'b0, GPIO_REG_DIR,      32'h0,        32'h3C, 8'h2E, 8'h3C, "rd_dir");
    tbl[11] = mk(1'b1, GPIO_REG_DATA_IN,  32'hFF,       32'h0,  8'h2E, 8'h3C, "wr_din_ro");
    tbl[12] = mk(1'b0, GPIO_REG_DATA_IN,  32'h0,        32'h0,  8'h2E, 8'h3C, "rd_din");
    tbl[13] = mk(1'b1, GPIO_REG_IRQ_EDGE, 32'h1FF,      32'h0,  8'h2E, 8'h3C, "wr_edge");
    tbl[14] = mk(1'b0, GPIO_REG_IRQ_EDGE, 32'h0,        32'hFF, 8'h2E, 8'h3C, "rd_edge");
    tbl[15] = mk(1'b1, GPIO_REG_IRQ_EN,   32'hF01,      32'h0,  8'h2E, 8'h3C, "wr_en");
    tbl[16] = mk(1'b0, GPIO_REG_IRQ_EN,   32'h0,        32'h01, 8'h2E, 8'h3C, "rd_en");
    tbl[17] = mk(1'b1, GPIO_REG_OUT_SET,  32'hF0,       32'h0,  8'hFE, 8'h3C, "wr_set_f0");

    for (int i = 0; i < 18; i++) begin
      bus_cycle(tbl[i].we, tbl[i].idx, tbl[i].wd, !tbl[i].we, tbl[i].exp_rd, tbl[i].name);
      check({tbl[i].name, "_out"}, 32'(pin_out), 32'(tbl[i].exp_out));
      check({tbl[i].name, "_oe"}, 32'(pin_oe), 32'(tbl[i].exp_oe));
    end

`ifndef GPIO_DEBOUNCE_EN
    // Pin-to-DATA_IN latency of 3 cycles, PEND one cycle later, irq one more.
    check("irq_idle", 32'(irq), 32'h0);
    pin_in = 8'h01;
    cycles(2);
    rd(GPIO_REG_DATA_IN, 32'h00, "din_t2");
    rd(GPIO_REG_DATA_IN, 32'h01, "din_t3");
    check("irq_t4", 32'(irq), 32'h0);
    rd(GPIO_REG_IRQ_PEND, 32'h01, "pend_t4");
    check("irq_t5", 32'(irq), 32'h1);
    wr(GPIO_REG_IRQ_PEND, 32'h01);
    check("irq_lag_w1c", 32'(irq), 32'h1);
    cycles(1);
    check("irq_cleared", 32'(irq), 32'h0);
    rd(GPIO_REG_IRQ_PEND, 32'h00, "pend_w1c");
`else
    // Debounce: a 10-cycle glitch is rejected, a sustained level is accepted.
    pin_in = 8'h01;
    cycles(SETTLE);
    check("irq_deb_rise", 32'(irq), 32'h1);
    wr(GPIO_REG_IRQ_PEND, 32'hFF);
    cycles(1);
    check("irq_deb_clr", 32'(irq), 32'h0);
    pin_in = 8'h05;
    cycles(10);
    pin_in = 8'h01;
    cycles(SETTLE);
    rd(GPIO_REG_DATA_IN, 32'h01, "glitch_din");
    rd(GPIO_REG_IRQ_PEND, 32'h00, "glitch_pend");
    pin_in = 8'h05;
    cycles(19);
    rd(GPIO_REG_DATA_IN, 32'h05, "hold_din");
    cycles(21);
    pin_in = 8'h01;
    cycles(SETTLE);
    wr(GPIO_REG_IRQ_PEND, 32'hFF);
    rd(GPIO_REG_IRQ_PEND, 32'h00, "deb_pend_clr");
`endif

    // Falling-edge mode: rising edge on pin3 ignored, falling edge pended.
    wr(GPIO_REG_IRQ_EDGE, 32'h00);
    wr(GPIO_REG_IRQ_PEND, 32'hFF);
    pin_in = 8'h09;
    cycles(SETTLE);
    rd(GPIO_REG_IRQ_PEND, 32'h00, "rise_ignored");
    rd(GPIO_REG_DATA_IN, 32'h09, "din_09");
    pin_in = 8'h01;
    cycles(SETTLE);
    rd(GPIO_REG_IRQ_PEND, 32'h08, "fall_pend");
    check("irq_masked", 32'(irq), 32'h0);

    // Rising event on pin3 in the same cycle as W1C of bit3: bit stays set.
    wr(GPIO_REG_IRQ_EDGE, 32'hFF);
`ifndef GPIO_DEBOUNCE_EN
    pin_in = 8'h09;
    cycles(3);
    wr(GPIO_REG_IRQ_PEND, 32'h08);
    rd(GPIO_REG_IRQ_PEND, 32'h08, "set_wins");
`else
    pin_in = 8'h09;
    cycles(SETTLE);
    rd(GPIO_REG_IRQ_PEND, 32'h08, "deb_rise_pend");
`endif
    wr(GPIO_REG_IRQ_PEND, 32'hFF);
    rd(GPIO_REG_IRQ_PEND, 32'h00, "w1c_clear");

    // Reset asserted while a read response is on the bus.
    bus_req  = 1'b1;
    bus_we   = 1'b0;
    bus_addr = {GPIO_REG_DIR, 2'b00};
    @(posedge clk);
    #1;
    bus_req = 1'b0;
    check("ack_before_rst", 32'(bus_ack), 32'h1);
    rst_n = 1'b0;
    #1;
    check("ack_dropped", 32'(bus_ack), 32'h0);
    check("rdata_rst", bus_rdata, 32'h0);
    check("out_rst", 32'(pin_out), 32'h0);
    check("oe_rst", 32'(pin_oe), 32'h0);
    check("irq_rst", 32'(irq), 32'h0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd(GPIO_REG_DIR, 32'h00, "dir_after_rst");
    rd(GPIO_REG_IRQ_EDGE, 32'hFF, "edge_after_rst");
    rd(GPIO_REG_IRQ_EN, 32'h00, "en_after_rst");
    rd(GPIO_REG_DATA_OUT, 32'h00, "out_after_rst");
    cycles(SETTLE);
    // Pins held high through reset produce rising events once stable follows.
    rd(GPIO_REG_IRQ_PEND, 32'h09, "pend_after_rst");
    rd(GPIO_REG_DATA_IN, 32'h09, "din_after_rst");
    check("irq_after_rst", 32'(irq), 32'h0);

    cycles(2);
    check("sb_drain", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
